// File: rtl/iob_axistream_rx_packer.sv
// iob_axistream_rx_packer: packs AXI-Stream beats little-endian into words stored in a FWFT FIFO drained by CPU or DMA
module iob_axistream_rx_packer #(
    parameter int DATA_W      = 32,
    parameter int TDATA_W     = 8,
    parameter int FIFO_ADDR_W = 4
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic                   cke_i,
    input  logic                   enable_i,
    input  logic                   soft_reset_i,
    input  logic                   mode_i,
    input  logic                   tlast_clear_i,
    input  logic [FIFO_ADDR_W:0]   fifo_threshold_i,
    input  logic [TDATA_W-1:0]     axis_tdata_i,
    input  logic                   axis_tvalid_i,
    input  logic                   axis_tlast_i,
    output logic                   axis_tready_o,
    input  logic                   data_ren_i,
    output logic [DATA_W-1:0]      data_rdata_o,
    output logic [DATA_W-1:0]      sys_tdata_o,
    output logic                   sys_tvalid_o,
    input  logic                   sys_tready_i,
    output logic                   fifo_empty_o,
    output logic                   fifo_full_o,
    output logic [FIFO_ADDR_W:0]   fifo_level_o,
    output logic [DATA_W-1:0]      nwords_o,
    output logic                   tlast_detected_o,
    output logic                   interrupt_o
);
    localparam int R     = DATA_W / TDATA_W;
    localparam int BW    = (R > 1) ? $clog2(R) : 1;
    localparam int PW    = FIFO_ADDR_W + 1;
    localparam int DEPTH = 1 << FIFO_ADDR_W;

    logic [BW-1:0]     r_bcnt;
    logic [DATA_W-1:0] r_pword;
    logic [DATA_W-1:0] r_nwords;
    logic [DATA_W-1:0] r_hold;
    logic              r_tlast;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_head;
    logic              w_acc;
    logic              w_push;
    logic              w_pop;

    assign fifo_level_o     = r_wptr - r_rptr;
    assign fifo_empty_o     = r_wptr == r_rptr;
    assign fifo_full_o      = (r_wptr[FIFO_ADDR_W-1:0] == r_rptr[FIFO_ADDR_W-1:0]) & (r_wptr[FIFO_ADDR_W] != r_rptr[FIFO_ADDR_W]);
    assign axis_tready_o    = enable_i & ~soft_reset_i & ~fifo_full_o & ~r_tlast;
    assign w_acc            = axis_tvalid_i & axis_tready_o;
    assign w_push           = w_acc & (axis_tlast_i | (r_bcnt == BW'(R - 1)));
    assign w_pop            = ~soft_reset_i & enable_i & ~fifo_empty_o & (mode_i ? sys_tready_i : data_ren_i);
    assign w_head           = r_mem[r_rptr[FIFO_ADDR_W-1:0]];
    // an empty FIFO keeps showing the last word popped (zero after reset)
    assign data_rdata_o     = fifo_empty_o ? r_hold : w_head;
    assign sys_tdata_o      = data_rdata_o;
    assign sys_tvalid_o     = enable_i & mode_i & ~fifo_empty_o;
    assign nwords_o         = r_nwords;
    assign tlast_detected_o = r_tlast;
    assign interrupt_o      = (fifo_level_o >= fifo_threshold_i) & (|fifo_threshold_i);

    // merge the incoming beat into slot bcnt; untouched upper slots are already zero
    always_comb begin
        w_word = r_pword;
        for (int i = 0; i < R; i++)
            if (r_bcnt == BW'(i)) w_word[i*TDATA_W +: TDATA_W] = axis_tdata_i;
    end

    // FIFO storage, written at the tail on each push
    always_ff @(posedge clk_i)
        if (cke_i & w_push) r_mem[r_wptr[FIFO_ADDR_W-1:0]] <= w_word;

    // packing state, FIFO pointers, packet counter and tlast flag
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_bcnt   <= '0;
            r_pword  <= '0;
            r_nwords <= '0;
            r_hold   <= '0;
            r_tlast  <= 1'b0;
            r_wptr   <= '0;
            r_rptr   <= '0;
        end else if (cke_i) begin
            if (soft_reset_i) begin
                r_bcnt   <= '0;
                r_pword  <= '0;
                r_nwords <= '0;
                r_hold   <= '0;
                r_tlast  <= 1'b0;
                r_wptr   <= '0;
                r_rptr   <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PW'(1);
                if (w_pop) begin
                    r_rptr <= r_rptr + PW'(1);
                    r_hold <= w_head;
                end
                if (w_push) begin
                    r_bcnt  <= '0;
                    r_pword <= '0;
                end else if (w_acc) begin
                    r_bcnt  <= r_bcnt + BW'(1);
                    r_pword <= w_word;
                end
                r_nwords <= (tlast_clear_i ? '0 : r_nwords) + DATA_W'(w_push);
                if (w_acc & axis_tlast_i) r_tlast <= 1'b1;
                else if (tlast_clear_i)   r_tlast <= 1'b0;
            end
        end
    end
endmodule
